// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the 2:1 AXI4 read-channel arbiter.
//   state_t    : arbiter FSM states (IDLE, ADDR, DATA)
//   BURST_INCR : AXI ARBURST encoding for incrementing bursts
//   SIZE_4B    : AXI ARSIZE encoding for 4-byte beats
//   RESP_OKAY  : AXI RRESP encoding for a normal response
//   sat_inc8   : 8-bit increment that sticks at 255
// ---------------------------------------------------------------------------
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // The beat counter must not wrap, or an over-long burst could alias
    // back onto the expected length and hide the error.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/axi_rd_arb2_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arb2_if
// AXI4 read channel bundle (AR + R) used on both sides of the arbiter.
// Parameters:
//   ID_W   : ARID/RID width (master side ID_WIDTH, slave side ID_WIDTH+1)
//   ADDR_W : ARADDR width
//   DATA_W : RDATA width
// Modports:
//   master : the side that issues read requests and consumes read data
//   slave  : the side that accepts read requests and returns read data
// ---------------------------------------------------------------------------
interface axi_rd_arb2_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin picker, purely combinational.
// Ports:
//   req[1:0] : in  request lines, bit i = requester i
//   last     : in  index of the previous winner
//   winner   : out index of the requester to serve next
// With no request pending the output simply holds 'last'; the caller only
// registers the result when at least one request is present.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    // A lone requester wins outright; on a tie the one that did not win
    // last time goes first.
    always_comb begin
        winner = last;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = last;
        endcase
    end

endmodule

// File: rtl/axi_rd_arb2.sv
// ---------------------------------------------------------------------------
// axi_rd_arb2
// 2:1 AXI4 read-channel arbiter. Two masters share one AR/R path to a single
// slave. Round-robin grant, held from the AR handshake through RLAST; only
// one read is outstanding at a time. The grant index is prepended to ARID
// and checked against the top bit of RID on the way back. Beat count and
// RLAST placement are checked against ARLEN. Violations set sticky flags
// but never alter routing.
// Ports:
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   m0, m1        : master-side read channels (ID_WIDTH wide IDs)
//   s             : slave-side read channel (ID_WIDTH+1 wide IDs)
//   GRANT         : index of the currently / most recently granted master
//   BUSY          : high while a burst is in its address or data phase
//   ERR_ID        : sticky, a returned RID carried the wrong grant bit
//   ERR_LEN       : sticky, RLAST did not land on beat ARLEN+1
// ---------------------------------------------------------------------------
import axi_arb_pkg::*;

module axi_rd_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    axi_rd_arb2_if.slave  m0,
    axi_rd_arb2_if.slave  m1,
    axi_rd_arb2_if.master s,
    output logic          GRANT,
    output logic          BUSY,
    output logic          ERR_ID,
    output logic          ERR_LEN
);

    state_t                state;
    state_t                state_nxt;
    logic                  grant_r;
    logic                  winner;
    logic [7:0]            beat_cnt;
    logic [7:0]            exp_len;
    logic                  err_id_r;
    logic                  err_len_r;

    logic [1:0]            req;
    logic                  g_arvalid;
    logic                  g_rready;
    logic [ID_WIDTH-1:0]   g_arid;
    logic [ADDR_WIDTH-1:0] g_araddr;
    logic [7:0]            g_arlen;
    logic [2:0]            g_arsize;
    logic [1:0]            g_arburst;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_len_bad;

    assign req = {m1.ARVALID, m0.ARVALID};

    rr_arb2 u_rr (
        .req    (req),
        .last   (grant_r),
        .winner (winner)
    );

    // Granted master's AR payload and R-ready, selected by the held grant.
    assign g_arvalid = grant_r ? m1.ARVALID : m0.ARVALID;
    assign g_arid    = grant_r ? m1.ARID    : m0.ARID;
    assign g_araddr  = grant_r ? m1.ARADDR  : m0.ARADDR;
    assign g_arlen   = grant_r ? m1.ARLEN   : m0.ARLEN;
    assign g_arsize  = grant_r ? m1.ARSIZE  : m0.ARSIZE;
    assign g_arburst = grant_r ? m1.ARBURST : m0.ARBURST;
    assign g_rready  = grant_r ? m1.RREADY  : m0.RREADY;
    assign r_data    = s.RDATA;

    assign ar_hs = (state == ADDR) && g_arvalid && s.ARREADY;
    assign r_hs  = (state == DATA) && s.RVALID && g_rready;

    // beat_cnt is the zero-based index of the beat being accepted, so the
    // last beat must arrive exactly when it equals the latched ARLEN.
    assign r_len_bad = s.RLAST ? (beat_cnt != exp_len) : (beat_cnt == exp_len);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and all handshake routing. Every ready/valid toward
    // the masters and the slave is gated by state so nothing leaks out in
    // IDLE or while reset is held.
    always_comb begin
        state_nxt  = state;

        s.ARID     = '0;
        s.ARADDR   = '0;
        s.ARLEN    = '0;
        s.ARSIZE   = '0;
        s.ARBURST  = '0;
        s.ARVALID  = 1'b0;
        s.RREADY   = 1'b0;

        m0.ARREADY = 1'b0;
        m0.RID     = '0;
        m0.RDATA   = '0;
        m0.RRESP   = '0;
        m0.RLAST   = 1'b0;
        m0.RVALID  = 1'b0;

        m1.ARREADY = 1'b0;
        m1.RID     = '0;
        m1.RDATA   = '0;
        m1.RRESP   = '0;
        m1.RLAST   = 1'b0;
        m1.RVALID  = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = ADDR;
                end
            end

            ADDR: begin
                s.ARID    = {grant_r, g_arid};
                s.ARADDR  = g_araddr;
                s.ARLEN   = g_arlen;
                s.ARSIZE  = g_arsize;
                s.ARBURST = g_arburst;
                s.ARVALID = g_arvalid;
                if (grant_r) begin
                    m1.ARREADY = s.ARREADY;
                end else begin
                    m0.ARREADY = s.ARREADY;
                end
                if (ar_hs) begin
                    state_nxt = DATA;
                end
            end

            DATA: begin
                s.RREADY = g_rready;
                if (grant_r) begin
                    m1.RVALID = s.RVALID;
                    m1.RDATA  = r_data;
                    m1.RRESP  = s.RRESP;
                    m1.RLAST  = s.RLAST;
                    m1.RID    = s.RID[ID_WIDTH-1:0];
                end else begin
                    m0.RVALID = s.RVALID;
                    m0.RDATA  = r_data;
                    m0.RRESP  = s.RRESP;
                    m0.RLAST  = s.RLAST;
                    m0.RID    = s.RID[ID_WIDTH-1:0];
                end
                if (r_hs && s.RLAST) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, burst bookkeeping and sticky error flags. GRANT resets to 1 so
    // that master 0 wins the first tie. The grant only moves in IDLE, so it
    // keeps naming the last winner between bursts.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant_r   <= 1'b1;
            beat_cnt  <= 8'd0;
            exp_len   <= 8'd0;
            err_id_r  <= 1'b0;
            err_len_r <= 1'b0;
        end else begin
            if ((state == IDLE) && (|req)) begin
                grant_r <= winner;
            end
            if (ar_hs) begin
                exp_len  <= g_arlen;
                beat_cnt <= 8'd0;
            end
            if (r_hs) begin
                beat_cnt <= sat_inc8(beat_cnt);
                if (s.RID[ID_WIDTH] != grant_r) begin
                    err_id_r <= 1'b1;
                end
                if (r_len_bad) begin
                    err_len_r <= 1'b1;
                end
            end
        end
    end

    assign GRANT   = grant_r;
    assign BUSY    = (state != IDLE);
    assign ERR_ID  = err_id_r;
    assign ERR_LEN = err_len_r;

endmodule

// File: tb/tb_axi_rd_arb2.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arb2
// Self-checking bench for the 2:1 AXI read arbiter. The bench plays both
// masters and the slave. Expected grant order and expected R beats are
// queued as stimulus is driven and popped as the arbiter presents them.
// ---------------------------------------------------------------------------
import axi_arb_pkg::*;

module tb_axi_rd_arb2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic grant, busy, err_id, err_len;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t beat_q[$];
    int    grant_q[$];

    logic [31:0] req_addr [2];
    logic [7:0]  req_len  [2];
    logic [3:0]  req_id   [2];

    always #5 clk = ~clk;

    axi_rd_arb2_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m0_if ();
    axi_rd_arb2_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m1_if ();
    axi_rd_arb2_if #(.ID_W(5), .ADDR_W(32), .DATA_W(32)) s_if ();

    axi_rd_arb2 #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ID_WIDTH   (4)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .GRANT   (grant),
        .BUSY    (busy),
        .ERR_ID  (err_id),
        .ERR_LEN (err_len)
    );

    function automatic logic m_rvalid(input int m);
        return (m == 0) ? m0_if.RVALID : m1_if.RVALID;
    endfunction

    function automatic logic m_arready(input int m);
        return (m == 0) ? m0_if.ARREADY : m1_if.ARREADY;
    endfunction

    function automatic logic m_rlast(input int m);
        return (m == 0) ? m0_if.RLAST : m1_if.RLAST;
    endfunction

    function automatic logic [31:0] m_rdata(input int m);
        return (m == 0) ? m0_if.RDATA : m1_if.RDATA;
    endfunction

    function automatic logic [1:0] m_rresp(input int m);
        return (m == 0) ? m0_if.RRESP : m1_if.RRESP;
    endfunction

    function automatic logic [3:0] m_rid(input int m);
        return (m == 0) ? m0_if.RID : m1_if.RID;
    endfunction

    task automatic init_inputs();
        m0_if.ARID = '0; m0_if.ARADDR = '0; m0_if.ARLEN = '0;
        m0_if.ARSIZE = '0; m0_if.ARBURST = '0; m0_if.ARVALID = 1'b0;
        m0_if.RREADY = 1'b1;
        m1_if.ARID = '0; m1_if.ARADDR = '0; m1_if.ARLEN = '0;
        m1_if.ARSIZE = '0; m1_if.ARBURST = '0; m1_if.ARVALID = 1'b0;
        m1_if.RREADY = 1'b1;
        s_if.ARREADY = 1'b1;
        s_if.RID = '0; s_if.RDATA = '0; s_if.RRESP = '0;
        s_if.RLAST = 1'b0; s_if.RVALID = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        init_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] addr,
                           input logic [7:0] len, input logic [3:0] id);
        req_addr[m] = addr;
        req_len[m]  = len;
        req_id[m]   = id;
        if (m == 0) begin
            m0_if.ARID = id; m0_if.ARADDR = addr; m0_if.ARLEN = len;
            m0_if.ARSIZE = SIZE_4B; m0_if.ARBURST = BURST_INCR;
            m0_if.ARVALID = 1'b1;
        end else begin
            m1_if.ARID = id; m1_if.ARADDR = addr; m1_if.ARLEN = len;
            m1_if.ARSIZE = SIZE_4B; m1_if.ARBURST = BURST_INCR;
            m1_if.ARVALID = 1'b1;
        end
    endtask

    task automatic drop_req(input int m);
        if (m == 0) m0_if.ARVALID = 1'b0;
        else        m1_if.ARVALID = 1'b0;
    endtask

    // Waits (bounded) for the slave-side AR, checks it against the next
    // expected grant, then lets the handshake complete on the next edge.
    task automatic serve_ar(output int lat);
        int   exp_m;
        int   oth;
        logic found;
        logic [4:0] exp_arid;
        exp_m = grant_q.pop_front();
        oth   = 1 - exp_m;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (s_if.ARVALID === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL ar_timeout: S_ARVALID got 0 expected 1 within 20 cycles");
            return;
        end
        exp_arid = {exp_m[0], req_id[exp_m]};
        checks++;
        if (s_if.ARID !== exp_arid) begin
            errors++;
            $display("[TB] FAIL s_arid: got %h expected %h", s_if.ARID, exp_arid);
        end
        checks++;
        if (s_if.ARADDR !== req_addr[exp_m] || s_if.ARLEN !== req_len[exp_m]) begin
            errors++;
            $display("[TB] FAIL s_ar_payload: got addr %h len %0d expected addr %h len %0d",
                     s_if.ARADDR, s_if.ARLEN, req_addr[exp_m], req_len[exp_m]);
        end
        checks++;
        if (grant !== exp_m[0]) begin
            errors++;
            $display("[TB] FAIL grant: got %b expected %b", grant, exp_m[0]);
        end
        checks++;
        if (m_arready(exp_m) !== 1'b1 || m_arready(oth) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arready_route: got granted %b other %b expected 1 0",
                     m_arready(exp_m), m_arready(oth));
        end
        @(posedge clk);
        #1;
    endtask

    // Slave returns nbeats beats, RLAST on the final one, with the given
    // top RID bit. Each beat is queued as expected output and checked at
    // the granted master on the following negedge.
    task automatic slave_burst(input int exp_m, input int nbeats, input logic rid_top);
        beat_t b;
        beat_t e;
        int    oth;
        oth = 1 - exp_m;
        for (int i = 0; i < nbeats; i++) begin
            b.m    = exp_m;
            b.data = $urandom;
            b.resp = 2'($urandom_range(0, 3));
            b.last = (i == nbeats - 1);
            b.id   = req_id[exp_m];
            beat_q.push_back(b);
            s_if.RVALID = 1'b1;
            s_if.RDATA  = b.data;
            s_if.RRESP  = b.resp;
            s_if.RLAST  = b.last;
            s_if.RID    = {rid_top, b.id};
            @(negedge clk);
            e = beat_q.pop_front();
            checks++;
            if (m_rvalid(e.m) !== 1'b1 || m_rvalid(1 - e.m) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rvalid_route: got granted %b other %b expected 1 0",
                         m_rvalid(e.m), m_rvalid(1 - e.m));
            end
            checks++;
            if (m_rdata(e.m) !== e.data || m_rresp(e.m) !== e.resp ||
                m_rlast(e.m) !== e.last || m_rid(e.m) !== e.id) begin
                errors++;
                $display("[TB] FAIL r_payload: got data %h resp %0d last %b id %h expected %h %0d %b %h",
                         m_rdata(e.m), m_rresp(e.m), m_rlast(e.m), m_rid(e.m),
                         e.data, e.resp, e.last, e.id);
            end
            checks++;
            if (s_if.RREADY !== 1'b1 || s_if.ARVALID !== 1'b0 ||
                m_arready(oth) !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL data_phase: got rready %b s_arvalid %b other_arready %b busy %b expected 1 0 0 1",
                         s_if.RREADY, s_if.ARVALID, m_arready(oth), busy);
            end
            @(posedge clk);
            #1;
        end
        s_if.RVALID = 1'b0;
        s_if.RLAST  = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_if.ARVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_gap: got busy %b s_arvalid %b expected 0 0",
                     busy, s_if.ARVALID);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        m0_if.ARVALID = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 1'b1 || busy !== 1'b0 || err_id !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got grant %b busy %b err_id %b err_len %b expected 1 0 0 0",
                     grant, busy, err_id, err_len);
        end
        checks++;
        if (s_if.ARVALID !== 1'b0 || s_if.RREADY !== 1'b0 || m0_if.ARREADY !== 1'b0 ||
            m1_if.ARREADY !== 1'b0 || m0_if.RVALID !== 1'b0 || m1_if.RVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshakes: got s_arvalid %b s_rready %b arready %b%b rvalid %b%b expected all 0",
                     s_if.ARVALID, s_if.RREADY, m0_if.ARREADY, m1_if.ARREADY,
                     m0_if.RVALID, m1_if.RVALID);
        end
        m0_if.ARVALID = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_m0();
        int lat;
        set_req(0, 32'h0000_0100, 8'd4, 4'h3);
        grant_q.push_back(0);
        serve_ar(lat);
        drop_req(0);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("[TB] FAIL ar_latency: got %0d expected 2", lat);
        end
        slave_burst(0, 5, 1'b0);
        checks++;
        if (grant !== 1'b0 || err_id !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_status: got grant %b err_id %b err_len %b expected 0 0 0",
                     grant, err_id, err_len);
        end
    endtask

    task automatic test_both_from_reset();
        int lat;
        apply_reset();
        set_req(0, 32'h0000_0200, 8'd1, 4'h5);
        set_req(1, 32'h0000_0300, 8'd1, 4'h6);
        grant_q.push_back(0);
        serve_ar(lat);
        drop_req(0);
        slave_burst(0, 2, 1'b0);
        grant_q.push_back(1);
        serve_ar(lat);
        drop_req(1);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("[TB] FAIL rearb_gap: got %0d expected 1", lat);
        end
        slave_burst(1, 2, 1'b1);
        checks++;
        if (err_id !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_errs: got err_id %b err_len %b expected 0 0", err_id, err_len);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int em;
        set_req(0, 32'h0000_0400, 8'd0, 4'h1);
        set_req(1, 32'h0000_0500, 8'd0, 4'h2);
        for (int k = 0; k < 4; k++) begin
            em = k % 2;
            grant_q.push_back(em);
            serve_ar(lat);
            slave_burst(em, 1, em[0]);
        end
        drop_req(0);
        drop_req(1);
    endtask

    task automatic test_short_burst();
        int lat;
        checks++;
        if (err_len !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_len_pre: got %b expected 0", err_len);
        end
        set_req(0, 32'h0000_0600, 8'd4, 4'h7);
        grant_q.push_back(0);
        serve_ar(lat);
        drop_req(0);
        slave_burst(0, 3, 1'b0);
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_len_set: got %b expected 1", err_len);
        end
        set_req(1, 32'h0000_0700, 8'd2, 4'h8);
        grant_q.push_back(1);
        serve_ar(lat);
        drop_req(1);
        slave_burst(1, 3, 1'b1);
        checks++;
        if (err_len !== 1'b1 || err_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_len_sticky: got err_len %b err_id %b expected 1 0", err_len, err_id);
        end
    endtask

    task automatic test_bad_rid();
        int lat;
        set_req(0, 32'h0000_0800, 8'd1, 4'h9);
        grant_q.push_back(0);
        serve_ar(lat);
        drop_req(0);
        slave_burst(0, 2, 1'b1);
        checks++;
        if (err_id !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_id_set: got %b expected 1", err_id);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        set_req(0, 32'h0000_0900, 8'd3, 4'hA);
        grant_q.push_back(0);
        serve_ar(lat);
        drop_req(0);
        s_if.RVALID = 1'b1;
        s_if.RDATA  = 32'h1111_1111;
        s_if.RID    = 5'h0A;
        s_if.RLAST  = 1'b0;
        @(posedge clk);
        #1;
        s_if.RDATA  = 32'h2222_2222;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m0_if.RVALID !== 1'b0 || s_if.RREADY !== 1'b0 || s_if.ARVALID !== 1'b0 ||
            m0_if.ARREADY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: got m0_rvalid %b s_rready %b s_arvalid %b m0_arready %b busy %b expected all 0",
                     m0_if.RVALID, s_if.RREADY, s_if.ARVALID, m0_if.ARREADY, busy);
        end
        checks++;
        if (grant !== 1'b1 || err_id !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_regs: got grant %b err_id %b err_len %b expected 1 0 0",
                     grant, err_id, err_len);
        end
        s_if.RVALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 32'h0000_0A00, 8'd1, 4'hB);
        grant_q.push_back(0);
        serve_ar(lat);
        drop_req(0);
        slave_burst(0, 2, 1'b0);
        checks++;
        if (grant !== 1'b0 || err_id !== 1'b0 || err_len !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_burst: got grant %b err_id %b err_len %b expected 0 0 0",
                     grant, err_id, err_len);
        end
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_both_from_reset();
        test_back_to_back();
        test_short_burst();
        test_bad_rid();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_rd_arb2.md
Name: axi_rd_arb2

Overview:
- 2:1 AXI4 read-channel arbiter. Two traffic masters share one AR/R path to a single slave, or to the spy-monitored interconnect port.
- Round-robin grant, locked for the whole burst (AR handshake through RLAST). One outstanding read at a time.
- Grant index is prepended to ARID. RID, beat count and RLAST are checked on return; violations set sticky error flags.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, read data width
ID_WIDTH, 4, master-side ID width (slave side is ID_WIDTH+1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  async active-low reset
M{0,1}_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  per-master AR payload
M{0,1}_ARVALID  in  1  per-master AR valid
M{0,1}_ARREADY  out  1  per-master AR ready
M{0,1}_RID/RDATA/RRESP  out  ID_WIDTH/DATA_WIDTH/2  per-master R payload
M{0,1}_RVALID/RLAST  out  1/1  per-master R valid, last
M{0,1}_RREADY  in  1  per-master R ready
S_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  ID_WIDTH+1/ADDR_WIDTH/8/3/2  slave AR payload
S_ARVALID  out  1  slave AR valid
S_ARREADY  in  1  slave AR ready
S_RID/RDATA/RRESP/RLAST  in  ID_WIDTH+1/DATA_WIDTH/2/1  slave R payload
S_RVALID  in  1  slave R valid
S_RREADY  out  1  slave R ready
GRANT  out  1  index of currently/last granted master
BUSY  out  1  high in ADDR or DATA state
ERR_ID  out  1  sticky: RID top bit != GRANT on any beat
ERR_LEN  out  1  sticky: RLAST not on beat ARLEN+1

Behaviour:
- Reset values:
  - state=IDLE, GRANT=1 (so M0 wins first tie), beat_cnt=0, exp_len=0, ERR_ID=ERR_LEN=0.
  - All VALID/READY outputs are 0. They are combinationally gated by state, so they are 0 during and immediately after reset.
- State IDLE:
  - No ready/valid asserted toward masters or slave.
  - If M0_ARVALID|M1_ARVALID: pick the requester. A single requester wins outright. If both request, the winner is the master != GRANT.
  - Register winner into GRANT, go to ADDR. Latency: ARVALID sampled -> S_ARVALID high next cycle.
- State ADDR:
  - S_AR* is a combinational mux of the granted master's AR payload.
  - S_ARID = {GRANT, Mg_ARID}. S_ARVALID = Mg_ARVALID. Mg_ARREADY = S_ARREADY. Non-granted ARREADY=0.
  - On S_ARVALID&S_ARREADY: latch exp_len=ARLEN, beat_cnt=0, go to DATA.
  - If the granted master drops ARVALID before handshake (protocol violation), stay in ADDR. There is no timeout.
- State DATA:
  - Mg_RVALID = S_RVALID. Mg_RDATA/RRESP/RLAST pass through. Mg_RID = S_RID[ID_WIDTH-1:0]. S_RREADY = Mg_RREADY.
  - Non-granted RVALID=0; its RDATA/RID/RRESP/RLAST are driven 0.
  - AR side fully blocked: both ARREADY=0, S_ARVALID=0.
  - Each R handshake: beat_cnt++ (8-bit, saturating at 255). ERR_ID set if S_RID[ID_WIDTH] != GRANT.
  - ERR_LEN set on:
    - RLAST with beat_cnt != exp_len, or
    - a non-last beat with beat_cnt == exp_len.
  - Handshake with RLAST: return to IDLE. GRANT stays holding the last winner for round-robin.
- Error flags are sticky until reset. They do not alter routing; the burst still completes on the slave's RLAST.
- Simultaneous new request on the RLAST cycle: not accepted that cycle. Arbitration occurs in IDLE the next cycle, so minimum gap is one idle cycle between bursts.
- Reset mid-burst: returns to IDLE immediately. The in-flight slave burst is abandoned; reset of the slave is a system-level requirement.
- BUSY = (state != IDLE).

Decomposition:
- Package axi_arb_pkg: state enum (IDLE, ADDR, DATA); AXI burst/size/resp constants (BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00).
- One natural sub-module: rr_arb2, a 2-requester round-robin picker. Inputs: req[1:0], last. Output: winner. Purely combinational. The top block registers the result.

Test Plan:
- M0 only, ARADDR=0x100, ARLEN=4, slave returns 5 beats RLAST on 5th -> S_ARID=0x0X with top bit 0, M0 sees 5 beats, M1_RVALID never high, GRANT=0, ERRs=0.
- M0 and M1 request same cycle from reset -> M0 granted first; after its RLAST, M1 granted with 1 idle cycle gap; S_ARID top bit=1 for M1 burst.
- Both request continuously for 4 bursts -> grant order 0,1,0,1.
- Slave asserts RLAST on beat 3 of ARLEN=4 burst -> ERR_LEN=1 and stays set; arbiter returns to IDLE and serves next request normally.
- Slave returns RID top bit=1 while GRANT=0 -> ERR_ID=1; data still routed to M0.
- ARESETN low during DATA beat 2 -> all VALID/READY outputs 0 asynchronously, GRANT=1, ERRs cleared; after release M0 request is granted normally.
